// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   word width, byte-offset width and the latency counter width.
//   No ports; imported by dmem_responder and dmem_array.
package dmem_responder_pkg;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W    = 4;

  // Encoding 2'd3 is unused; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
//   Single-port word array: synchronous write, asynchronous read.
//   Contents are never cleared by reset.
// Ports:
//   clk_i    clock
//   we_i     write enable, sampled on the rising edge
//   waddr_i  word index for the write
//   wdata_i  write data
//   raddr_i  word index for the combinational read
//   rdata_o  read data (combinational)
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   MEM-stage data-memory responder with a fixed access latency. Holds the
//   pipeline with stall_o until the access completes, then pulses ack_o for
//   one cycle; err_o flags a rejected access during that pulse.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-low reset
//   MemRead_i   read request, held until ack
//   MemWrite_i  write request, held until ack
//   addr_i      byte address (must be word aligned and in range)
//   wdata_i     write data
//   rdata_o     read data, registered, holds until the next read completes
//   stall_o     pipeline freeze, combinational
//   ack_o       one-cycle completion pulse, registered
//   err_o       access rejected, valid with ack_o, registered
//
// state | meaning
// IDLE  | waiting for a request; latches the request when one appears
// BUSY  | counting down the remaining latency
// DONE  | ack_o (and err_o if rejected) high for this one cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              stall_o,
  output logic              ack_o,
  output logic              err_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = WORD_W - OFFSET_W;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q, wr_q, bad_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;

  logic              req, req_bad;
  logic              commit, mem_we;
  logic              op_rd, op_wr, op_bad;
  logic [AW-1:0]     op_idx;
  logic [WORD_W-1:0] op_wdata, mem_rdata;

  assign req     = MemRead_i | MemWrite_i;
  // Out-of-range word indices are rejected rather than aliased.
  assign req_bad = (MemRead_i & MemWrite_i)
                 | (addr_i[OFFSET_W-1:0] != '0)
                 | (addr_i[WORD_W-1:OFFSET_W] >= IDX_W'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (req) state_n = (LATENCY == 1) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_W'(1)) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is also the acceptance edge, so the
  // operation comes straight from the inputs; otherwise from the latches.
  always_comb begin
    stall_o = req & (state_q != ST_DONE);
    commit  = (state_n == ST_DONE) & (state_q != ST_DONE);
    if (state_q == ST_IDLE) begin
      op_rd    = MemRead_i;
      op_wr    = MemWrite_i;
      op_bad   = req_bad;
      op_idx   = addr_i[AW+OFFSET_W-1:OFFSET_W];
      op_wdata = wdata_i;
    end else begin
      op_rd    = rd_q;
      op_wr    = wr_q;
      op_bad   = bad_q;
      op_idx   = idx_q;
      op_wdata = wdata_q;
    end
  end

  // Reset on the commit edge abandons the write.
  assign mem_we = commit & op_wr & ~op_bad & rst_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_o <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= commit;
      err_o <= commit & op_bad;
      if (state_q == ST_IDLE && req) begin
        cnt_q   <= CNT_W'(LATENCY - 1);
        rd_q    <= MemRead_i;
        wr_q    <= MemWrite_i;
        bad_q   <= req_bad;
        idx_q   <= addr_i[AW+OFFSET_W-1:OFFSET_W];
        wdata_q <= wdata_i;
      end else if (state_q == ST_BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit && op_rd) begin
        rdata_o <= op_bad ? '0 : mem_rdata;
      end
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .waddr_i (op_idx),
    .wdata_i (op_wdata),
    .raddr_i (op_idx),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. Two instances: u3 (LATENCY=3) and
//   u1 (LATENCY=1). The driver pushes the expected ack result per request;
//   per-instance monitors pop and compare on every ack_o.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd3, wr3, rd1, wr1;
  logic [31:0] a3, d3, a1, d1;
  logic [31:0] q3, q1;
  logic        st3, st1, ack3, ack1, err3, err1;

  exp_t sb3[$];
  exp_t sb1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u3 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd3), .MemWrite_i(wr3),
    .addr_i(a3), .wdata_i(d3), .rdata_o(q3), .stall_o(st3),
    .ack_o(ack3), .err_o(err3)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(a1), .wdata_i(d1), .rdata_o(q1), .stall_o(st1),
    .ack_o(ack1), .err_o(err1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack3) begin
      if (sb3.size() == 0) begin
        check("u3 ack with empty scoreboard", 32'(ack3), 32'd0);
      end else begin
        exp_t e;
        e = sb3.pop_front();
        check("u3 err", 32'(err3), 32'(e.err));
        if (e.chk_rd) check("u3 rdata", q3, e.rdata);
      end
    end else begin
      check("u3 err without ack", 32'(err3), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (ack1) begin
      if (sb1.size() == 0) begin
        check("u1 ack with empty scoreboard", 32'(ack1), 32'd0);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        check("u1 err", 32'(err1), 32'(e.err));
        if (e.chk_rd) check("u1 rdata", q1, e.rdata);
      end
    end else begin
      check("u1 err without ack", 32'(err1), 32'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 with the request removed, so
  // consecutive calls exercise the single IDLE turnaround cycle.
  task automatic do_req(input bit one, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic chk_rd, input int drop_at);
    int   lat, cyc, stalls;
    bit   got;
    exp_t e;
    lat = one ? 1 : 3;
    e.rdata = exp_rd; e.err = exp_err; e.chk_rd = chk_rd;
    if (one) begin
      rd1 = rd; wr1 = wr; a1 = a; d1 = d; sb1.push_back(e);
    end else begin
      rd3 = rd; wr3 = wr; a3 = a; d3 = d; sb3.push_back(e);
    end
    cyc = 0; stalls = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (one ? ack1 : ack3) begin
        got = 1'b1;
        check($sformatf("u%0d stall low in DONE addr %h", lat, a), 32'(one ? st1 : st3), 32'd0);
      end else begin
        if (one ? st1 : st3) stalls++;
        cyc++;
        @(posedge clk); #1;
        if (drop_at != 0 && cyc == drop_at) begin
          if (one) {rd1, wr1} = 2'b00;
          else     {rd3, wr3} = 2'b00;
        end
      end
    end
    check($sformatf("u%0d ack seen addr %h", lat, a), 32'(got), 32'd1);
    check($sformatf("u%0d ack latency addr %h", lat, a), 32'(cyc), 32'(lat));
    check($sformatf("u%0d stall cycles addr %h", lat, a), 32'(stalls),
          32'((drop_at != 0) ? drop_at : lat));
    @(posedge clk); #1;
    if (one) {rd1, wr1} = 2'b00;
    else     {rd3, wr3} = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rd3 = 1'b0; wr3 = 1'b0; a3 = '0; d3 = '0;
    rd1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset u3 rdata", q3, 32'd0);
    check("reset u3 ack", 32'(ack3), 32'd0);
    check("reset u3 stall", 32'(st3), 32'd0);
    check("reset u1 rdata", q1, 32'd0);
    check("reset u3 state", 32'(u3.state_q), 32'(ST_IDLE));
    @(posedge clk); #1;

    // u3: write/read, misaligned, both-set, out-of-range, boundary, drop
    do_req(0, 1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 0);
    do_req(0, 1'b0, 1'b1, 32'h13,  32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 0);
    do_req(0, 1'b1, 1'b1, 32'h10,  32'h0,        32'h0,        1'b1, 1'b1, 0);
    do_req(0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 0);
    do_req(0, 1'b0, 1'b1, 32'h0,   32'h0BADF00D, 32'h0,        1'b0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0, 1'b1, 0);
    do_req(0, 1'b0, 1'b1, 32'h400, 32'h55555555, 32'h0BADF00D, 1'b1, 1'b1, 0);
    do_req(0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h0BADF00D, 1'b0, 1'b1, 0);
    do_req(0, 1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1'b1, 0);
    do_req(0, 1'b0, 1'b1, 32'h3FC, 32'h0F0F0F0F, 32'h0,        1'b0, 1'b0, 0);
    do_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0,        32'h0F0F0F0F, 1'b0, 1'b1, 0);
    do_req(0, 1'b0, 1'b1, 32'h24,  32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1);
    do_req(0, 1'b1, 1'b0, 32'h24,  32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 0);

    // u1: single-cycle latency
    do_req(1, 1'b0, 1'b1, 32'h0,   32'h12345678, 32'h0,        1'b0, 1'b0, 0);
    do_req(1, 1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0, 1'b1, 0);
    do_req(1, 1'b0, 1'b1, 32'h8,   32'h13579BDF, 32'h0,        1'b0, 1'b0, 0);
    do_req(1, 1'b1, 1'b0, 32'h8,   32'h0,        32'h13579BDF, 1'b0, 1'b1, 0);
    do_req(1, 1'b1, 1'b0, 32'h2,   32'h0,        32'h0,        1'b1, 1'b1, 0);

    // u3: reset while BUSY abandons the write
    do_req(0, 1'b0, 1'b1, 32'h20,  32'hAAAA5555, 32'h0,        1'b0, 1'b0, 0);
    wr3 = 1'b1; a3 = 32'h20; d3 = 32'h11111111;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; wr3 = 1'b0;
    @(negedge clk);
    check("u3 state after mid-busy reset", 32'(u3.state_q), 32'(ST_IDLE));
    check("u3 rdata after mid-busy reset", q3, 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("u3 no ack after mid-busy reset", 32'(ack3), 32'd0);
    end
    @(posedge clk); #1;
    do_req(0, 1'b1, 1'b0, 32'h20,  32'h0,        32'hAAAA5555, 1'b0, 1'b1, 0);

    repeat (3) @(negedge clk);
    check("u3 scoreboard drained", 32'(sb3.size()), 32'd0);
    check("u1 scoreboard drained", 32'(sb1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
